// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared data-memory/MMIO bus.
// Port 0 is the CPU load/store unit and port 1 is the DMA/boot loader.
// A port may hold the bus for a bounded multi-beat burst by asserting lock.
// Read data is captured one cycle after the grant.
module mem_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic        r0_lock,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic        r1_lock,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_rvalid,
  output logic        r1_rvalid,
  output logic [31:0] r0_rdata,
  output logic [31:0] r1_rdata,
  output logic        memwrite,
  output logic        memread,
  output logic [31:0] addr,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  localparam int CW      = $clog2(MAX_BURST + 1);
  // With a one-cycle burst limit there is nothing to lock, so lock is ignored.
  localparam bit LOCK_EN = (MAX_BURST > 1);

  typedef enum logic [1:0] {NONE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            burst_end;
  logic            gnt0, gnt1;

  // Owner state, last-granted pointer and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NONE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration and ownership transitions; an exiting owner still gets its last beat.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    cnt_inc   = cnt_q + CW'(1);
    burst_end = (cnt_inc == CW'(MAX_BURST));
    case (state_q)
      NONE: begin
        if (r0_req && (!r1_req || last_q)) gnt0 = 1'b1;
        else if (r1_req)                   gnt1 = 1'b1;
        if (gnt0) begin
          last_d = 1'b0;
          if (r0_lock && LOCK_EN) begin
            state_d = OWN0;
            cnt_d   = CW'(1);
          end
        end
        if (gnt1) begin
          last_d = 1'b1;
          if (r1_lock && LOCK_EN) begin
            state_d = OWN1;
            cnt_d   = CW'(1);
          end
        end
      end
      OWN0: begin
        gnt0  = r0_req;
        cnt_d = cnt_inc;
        if (!r0_lock || burst_end) begin
          state_d = NONE;
          cnt_d   = '0;
        end
      end
      OWN1: begin
        gnt1  = r1_req;
        cnt_d = cnt_inc;
        if (!r1_lock || burst_end) begin
          state_d = NONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // Grants are suppressed while reset is held so no strobe reaches the bus.
  assign r0_gnt = gnt0 & rst_n;
  assign r1_gnt = gnt1 & rst_n;

  // Bus mux: granted port drives the bus, otherwise everything is zero.
  always_comb begin
    memwrite  = 1'b0;
    memread   = 1'b0;
    addr      = '0;
    writedata = '0;
    if (r0_gnt) begin
      memwrite  = r0_we;
      memread   = ~r0_we;
      addr      = r0_addr;
      writedata = r0_wdata;
    end else if (r1_gnt) begin
      memwrite  = r1_we;
      memread   = ~r1_we;
      addr      = r1_addr;
      writedata = r1_wdata;
    end
  end

  // Registered read return; rdata holds until the next read to the same port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= r0_gnt & ~r0_we;
      r1_rvalid <= r1_gnt & ~r1_we;
      if (r0_gnt && !r0_we) r0_rdata <= readdata;
      if (r1_gnt && !r1_we) r1_rdata <= readdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small memory/MMIO model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        memwrite, memread;
  logic [31:0] addr, writedata, readdata;
  logic [15:0] sw;
  logic [31:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .memwrite(memwrite), .memread(memread), .addr(addr), .writedata(writedata),
    .readdata(readdata)
  );

  // Memory model: switches at 0x404, word-indexed RAM elsewhere.
  assign readdata = (addr == 32'h404) ? {16'h0000, sw} : mem[addr[9:2]];

  always @(posedge clk) begin
    if (memwrite) mem[addr[9:2]] <= writedata;
  end

  task automatic idle();
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    r0_req = 1; r1_req = 1; r0_we = 1; r1_we = 1;
    #1;
    n_tests++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %b%b want 00", r0_gnt, r1_gnt); end
    n_tests++; if (memwrite !== 1'b0 || memread !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got w=%b r=%b want 0 0", memwrite, memread); end
    n_tests++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b%b want 00", r0_rvalid, r1_rvalid); end
    n_tests++; if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h %h want 0 0", r0_rdata, r1_rdata); end
    @(negedge clk);
    idle();
    rst_n = 1;
  endtask

  task automatic test_read();
    do_reset();
    @(negedge clk);
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    #1;
    n_tests++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin n_fail++; $display("FAIL read_gnt got %b%b want 10", r0_gnt, r1_gnt); end
    n_tests++; if (memread !== 1'b1 || memwrite !== 1'b0 || addr !== 32'h10) begin n_fail++; $display("FAIL read_bus got r=%b w=%b a=%h want 1 0 10", memread, memwrite, addr); end
    n_tests++; if (r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_early_rvalid got %b want 0", r0_rvalid); end
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_return got v=%b d=%h want 1 deadbeef", r0_rvalid, r0_rdata); end
    n_tests++; if (memread !== 1'b0 || addr !== 32'h0) begin n_fail++; $display("FAIL idle_bus got r=%b a=%h want 0 0", memread, addr); end
    @(negedge clk);
    #1;
    n_tests++; if (r0_rvalid !== 1'b0 || r0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_hold got v=%b d=%h want 0 deadbeef", r0_rvalid, r0_rdata); end
  endtask

  task automatic test_alternate();
    logic exp0;
    do_reset();
    @(negedge clk);
    r0_req = 1; r0_we = 1; r0_addr = 32'h20; r0_wdata = 32'h1111_0000;
    r1_req = 1; r1_we = 1; r1_addr = 32'h24; r1_wdata = 32'h2222_0000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp0 = (i % 2 == 0);
      n_tests++; if (r0_gnt !== exp0 || r1_gnt !== ~exp0) begin n_fail++; $display("FAIL alt_gnt cycle %0d got %b%b want %b%b", i, r0_gnt, r1_gnt, exp0, ~exp0); end
      n_tests++; if (memwrite !== 1'b1 || addr !== (exp0 ? 32'h20 : 32'h24)) begin n_fail++; $display("FAIL alt_bus cycle %0d got w=%b a=%h", i, memwrite, addr); end
    end
    @(negedge clk);
    idle();
    n_tests++; if (mem[8] !== 32'h1111_0000 || mem[9] !== 32'h2222_0000) begin n_fail++; $display("FAIL alt_mem got %h %h want 11110000 22220000", mem[8], mem[9]); end
  endtask

  task automatic test_burst();
    logic exp1;
    do_reset();
    @(negedge clk);
    r0_req = 1; r0_we = 1; r0_addr = 32'h40; r0_wdata = 32'h5;
    #1;
    n_tests++; if (r0_gnt !== 1'b1) begin n_fail++; $display("FAIL burst_pre got %b want 1", r0_gnt); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      r1_req = 1; r1_we = 1; r1_lock = 1; r1_addr = 32'h44; r1_wdata = i;
      #1;
      exp1 = (i != 8);
      n_tests++; if (r1_gnt !== exp1 || r0_gnt !== ~exp1) begin n_fail++; $display("FAIL burst_gnt cycle %0d got %b%b want %b%b", i, r0_gnt, r1_gnt, ~exp1, exp1); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_lock_idle();
    do_reset();
    @(negedge clk);
    r0_req = 1; r0_we = 1; r0_lock = 1; r0_addr = 32'h48; r0_wdata = 32'h7;
    #1;
    n_tests++; if (r0_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_first got %b want 1", r0_gnt); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      r0_req = 0; r1_req = 1; r1_we = 0; r1_addr = 32'h10;
      #1;
      n_tests++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || memread !== 1'b0 || memwrite !== 1'b0) begin n_fail++; $display("FAIL lock_idle cycle %0d got g=%b%b r=%b w=%b want all 0", i, r0_gnt, r1_gnt, memread, memwrite); end
    end
    @(negedge clk);
    r0_lock = 0;
    #1;
    n_tests++; if (r1_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_exit got %b want 0", r1_gnt); end
    @(negedge clk);
    #1;
    n_tests++; if (r1_gnt !== 1'b1 || memread !== 1'b1) begin n_fail++; $display("FAIL lock_after got g=%b r=%b want 1 1", r1_gnt, memread); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    @(negedge clk);
    idle();
    r1_req = 1; r1_we = 1; r1_lock = 1; r1_addr = 32'h400; r1_wdata = 32'hAAAA_0001;
    #1;
    n_tests++; if (r1_gnt !== 1'b1 || r0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_setup got g=%b d=%h want 1 deadbeef", r1_gnt, r0_rdata); end
    @(negedge clk);
    r1_wdata = 32'hBBBB_0002;
    #1;
    n_tests++; if (memwrite !== 1'b1 || r1_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_burst got w=%b g=%b want 1 1", memwrite, r1_gnt); end
    #1;
    rst_n = 0;
    #1;
    n_tests++; if (memwrite !== 1'b0 || r1_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_reset_strobe got w=%b g=%b want 0 0", memwrite, r1_gnt); end
    n_tests++; if (r0_rdata !== 32'h0 || r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rdata got d=%h v=%b%b want 0 00", r0_rdata, r0_rvalid, r1_rvalid); end
    @(negedge clk);
    rst_n = 1;
    idle();
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    r1_req = 1; r1_we = 0; r1_addr = 32'h404;
    #1;
    n_tests++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_tie got %b%b want 10", r0_gnt, r1_gnt); end
    n_tests++; if (mem[0] !== 32'hAAAA_0001) begin n_fail++; $display("FAIL mid_mem got %h want aaaa0001", mem[0]); end
    @(negedge clk);
    #1;
    n_tests++; if (r1_gnt !== 1'b1 || r0_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_next got g1=%b v0=%b want 1 1", r1_gnt, r0_rvalid); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    sw = 16'h00A5;
    @(negedge clk);
    r1_req = 1; r1_we = 0; r1_addr = 32'h404;
    #1;
    n_tests++; if (r1_gnt !== 1'b1 || memread !== 1'b1 || addr !== 32'h404) begin n_fail++; $display("FAIL b2b_read got g=%b r=%b a=%h want 1 1 404", r1_gnt, memread, addr); end
    @(negedge clk);
    idle();
    r0_req = 1; r0_we = 1; r0_addr = 32'h30; r0_wdata = 32'h0C0F_FEE0;
    #1;
    n_tests++; if (r0_gnt !== 1'b1 || memwrite !== 1'b1) begin n_fail++; $display("FAIL b2b_write got g=%b w=%b want 1 1", r0_gnt, memwrite); end
    n_tests++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL b2b_rdata got v=%b d=%h want 1 000000a5", r1_rvalid, r1_rdata); end
    n_tests++; if (r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_r0v_a got %b want 0", r0_rvalid); end
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_r0v_b got %b%b want 00", r0_rvalid, r1_rvalid); end
    n_tests++; if (mem[12] !== 32'h0C0F_FEE0) begin n_fail++; $display("FAIL b2b_mem got %h want 0c0ffee0", mem[12]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    sw = 16'h0;
    rst_n = 0;
    idle();
    test_reset();
    test_read();
    test_alternate();
    test_burst();
    test_lock_idle();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
